// File: rtl/controle_multiciclo.sv
// ============================================================================
//  controle_multiciclo : multicycle MIPS control FSM with instruction-retire counter
//  Revision: 1.0
// ============================================================================
`default_nettype none

module controle_multiciclo #(
  parameter int          CNT_WIDTH = 32,
  parameter logic [5:0]  OP_RTYPE  = 6'b000000,
  parameter logic [5:0]  OP_LW     = 6'b100011,
  parameter logic [5:0]  OP_SW     = 6'b101011,
  parameter logic [5:0]  OP_BEQ    = 6'b000100,
  parameter logic [5:0]  OP_J      = 6'b000010,
  parameter logic [5:0]  OP_ADDI   = 6'b001000
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic [5:0]           Opcode,
  input  logic                 MemReady,
  output logic                 PCWrite,
  output logic                 PCWriteCond,
  output logic                 IorD,
  output logic                 MemRead,
  output logic                 MemWrite,
  output logic                 IRWrite,
  output logic                 MemtoReg,
  output logic                 RegWrite,
  output logic                 RegDst,
  output logic                 ALUSrcA,
  output logic [1:0]           ALUSrcB,
  output logic [1:0]           ALUOp,
  output logic [1:0]           PCSource,
  output logic                 Halted,
  output logic [3:0]           State,
  output logic [CNT_WIDTH-1:0] InstrCount
);

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_FETCH     = 4'd1,
    S_DECODE    = 4'd2,
    S_MEM_ADDR  = 4'd3,
    S_MEM_READ  = 4'd4,
    S_MEM_WB    = 4'd5,
    S_MEM_WRITE = 4'd6,
    S_EXECUTE   = 4'd7,
    S_R_WB      = 4'd8,
    S_BRANCH    = 4'd9,
    S_JUMP      = 4'd10,
    S_ADDI_EX   = 4'd11,
    S_ADDI_WB   = 4'd12,
    S_TRAP      = 4'd15
  } state_t;

  state_t                state_q, state_d;
  logic [CNT_WIDTH-1:0]  instr_count_q, instr_count_d;
  logic                  retire;

  always_comb begin
    state_d = state_q;
    retire  = 1'b0;
    case (state_q)
      S_IDLE:      state_d = S_FETCH;
      S_FETCH:     if (MemReady) state_d = S_DECODE;
      S_DECODE: begin
        case (Opcode)
          OP_RTYPE:     state_d = S_EXECUTE;
          OP_LW, OP_SW: state_d = S_MEM_ADDR;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
          OP_ADDI:      state_d = S_ADDI_EX;
          default:      state_d = S_TRAP;
        endcase
      end
      S_MEM_ADDR:  state_d = (Opcode == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
      S_MEM_READ:  if (MemReady) state_d = S_MEM_WB;
      S_MEM_WRITE: begin
        if (MemReady) begin
          state_d = S_FETCH;
          retire  = 1'b1;
        end
      end
      S_EXECUTE:   state_d = S_R_WB;
      S_ADDI_EX:   state_d = S_ADDI_WB;
      S_MEM_WB, S_R_WB, S_ADDI_WB, S_BRANCH, S_JUMP: begin
        state_d = S_FETCH;
        retire  = 1'b1;
      end
      S_TRAP:      state_d = S_TRAP;
      default:     state_d = S_TRAP;
    endcase
    instr_count_d = retire ? instr_count_q + CNT_WIDTH'(1) : instr_count_q;
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q       <= S_IDLE;
      instr_count_q <= '0;
    end else begin
      state_q       <= state_d;
      instr_count_q <= instr_count_d;
    end
  end

  // Moore decode of the state; only FETCH's PC/IR enables look at MemReady
  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    MemtoReg    = 1'b0;
    RegWrite    = 1'b0;
    RegDst      = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    ALUOp       = 2'b00;
    PCSource    = 2'b00;
    Halted      = 1'b0;
    case (state_q)
      S_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        PCWrite = MemReady;
        IRWrite = MemReady;
      end
      S_DECODE:    ALUSrcB = 2'b11;
      S_MEM_ADDR, S_ADDI_EX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      S_MEM_READ: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      S_MEM_WRITE: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
      end
      S_MEM_WB: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
      end
      S_EXECUTE: begin
        ALUSrcA = 1'b1;
        ALUOp   = 2'b10;
      end
      S_R_WB: begin
        RegWrite = 1'b1;
        RegDst   = 1'b1;
      end
      S_ADDI_WB:   RegWrite = 1'b1;
      S_BRANCH: begin
        ALUSrcA     = 1'b1;
        ALUOp       = 2'b01;
        PCWriteCond = 1'b1;
        PCSource    = 2'b01;
      end
      S_JUMP: begin
        PCWrite  = 1'b1;
        PCSource = 2'b10;
      end
      S_TRAP:      Halted = 1'b1;
      default: begin
      end
    endcase
  end

  assign State      = state_q;
  assign InstrCount = instr_count_q;

endmodule

`default_nettype wire
